// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared joystick bit indices, scan codes and state types for arcade_input_ctrl
package arcade_input_pkg;

    localparam int JOY_R    = 0;
    localparam int JOY_L    = 1;
    localparam int JOY_D    = 2;
    localparam int JOY_U    = 3;
    localparam int JOY_BTN0 = 4;

    typedef enum logic [1:0] {
        ROT_NONE  = 2'd0,
        ROT_CW90  = 2'd1,
        ROT_180   = 2'd2,
        ROT_CCW90 = 2'd3
    } rotate_t;

    localparam logic [8:0] SC_UP      = 9'h175;
    localparam logic [8:0] SC_DOWN    = 9'h172;
    localparam logic [8:0] SC_LEFT    = 9'h16B;
    localparam logic [8:0] SC_RIGHT   = 9'h174;
    localparam logic [8:0] SC_FIRE0_A = 9'h029;
    localparam logic [8:0] SC_FIRE0_B = 9'h014;
    localparam logic [8:0] SC_FIRE1   = 9'h011;
    localparam logic [8:0] SC_START0  = 9'h005;
    localparam logic [8:0] SC_START1  = 9'h006;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COIN  = 2'd1,
        GAP   = 2'd2,
        START = 2'd3
    } coin_state_t;

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// rtl/arcade_input_ctrl_if.sv - input/output bundle between hps_io side and the game core
interface arcade_input_ctrl_if #(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 4
);
    logic [10:0]              ps2_key;
    logic [16*PLAYERS-1:0]    joystick;
    logic [1:0]               rotate;
    logic [PLAYERS-1:0]       autofire_en;
    logic [4*PLAYERS-1:0]     dir;
    logic [BUTTONS*PLAYERS-1:0] btn;
    logic [PLAYERS-1:0]       coin;
    logic [PLAYERS-1:0]       start;

    modport master (
        output ps2_key, joystick, rotate, autofire_en,
        input  dir, btn, coin, start
    );

    modport slave (
        input  ps2_key, joystick, rotate, autofire_en,
        output dir, btn, coin, start
    );
endinterface

// File: rtl/coin_start_seq.sv
// rtl/coin_start_seq.sv - per-player coin pulse, gap, then start level, timed in ce ticks
module coin_start_seq
    import arcade_input_pkg::*;
#(
    parameter int COIN_TICKS = 16
)(
    input  logic clk_sys,
    input  logic reset,
    input  logic ce,
    input  logic req,
    output logic coin,
    output logic start
);
    localparam int CW = $clog2(COIN_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(COIN_TICKS - 1);
    localparam logic [CW-1:0] FULL = CW'(COIN_TICKS);

    coin_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          req_q;

    // req_q resets high so a request held through reset cannot look like a new edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= 1'b1;
            coin  <= 1'b0;
            start <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            req_q <= req;
            coin  <= (state_nx == COIN);
            start <= (state_nx == START);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req && !req_q) begin
                    state_nx = COIN;
                    cnt_nx   = '0;
                end
            end
            COIN, GAP: begin
                if (ce) begin
                    if (cnt == LAST) begin
                        state_nx = (state == COIN) ? GAP : START;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            START: begin
                if (ce && cnt != FULL) cnt_nx = cnt + 1'b1;
                if (cnt_nx == FULL && !req) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: rtl/arcade_input_ctrl.sv
// rtl/arcade_input_ctrl.sv - keyboard/joystick merge, rotation, cancel, autofire and coin/start front end
// Optional autofire counter built only when INPUT_AUTOFIRE_EN is defined.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int PLAYERS    = 2,
    parameter int BUTTONS    = 4,
    parameter int COIN_TICKS = 16,
    parameter int AF_TICKS   = 8
)(
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce,
    arcade_input_ctrl_if.slave  io
);
    logic key_tog, key_evt;
    logic k_up, k_down, k_left, k_right, k_fire0, k_fire1, k_start0, k_start1;

    assign key_evt = io.ps2_key[10] ^ key_tog;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            key_tog  <= 1'b0;
            k_up     <= 1'b0;
            k_down   <= 1'b0;
            k_left   <= 1'b0;
            k_right  <= 1'b0;
            k_fire0  <= 1'b0;
            k_fire1  <= 1'b0;
            k_start0 <= 1'b0;
            k_start1 <= 1'b0;
        end else begin
            key_tog <= io.ps2_key[10];
            if (key_evt) begin
                case (io.ps2_key[8:0])
                    SC_UP:                  k_up     <= io.ps2_key[9];
                    SC_DOWN:                k_down   <= io.ps2_key[9];
                    SC_LEFT:                k_left   <= io.ps2_key[9];
                    SC_RIGHT:               k_right  <= io.ps2_key[9];
                    SC_FIRE0_A, SC_FIRE0_B: k_fire0  <= io.ps2_key[9];
                    SC_FIRE1:               k_fire1  <= io.ps2_key[9];
                    SC_START0:              k_start0 <= io.ps2_key[9];
                    SC_START1:              k_start1 <= io.ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

`ifdef INPUT_AUTOFIRE_EN
    localparam int AW = $clog2(AF_TICKS + 1);
    logic [AW-1:0] af_cnt;
    logic          af_phase;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (ce) begin
            if (af_cnt == AW'(AF_TICKS - 1)) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_af_en;
    assign unused_af_en = ^io.autofire_en;
`endif

    logic [4*PLAYERS-1:0]       dir_nx;
    logic [BUTTONS*PLAYERS-1:0] btn_nx;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [15:0]        kbd, raw;
        logic [3:0]         rot, cln;
        logic [BUTTONS-1:0] fire;
        logic               unused_raw;

        always_comb begin
            kbd = '0;
            if (p == 0) begin
                kbd[JOY_U]            = k_up;
                kbd[JOY_D]            = k_down;
                kbd[JOY_L]            = k_left;
                kbd[JOY_R]            = k_right;
                kbd[JOY_BTN0]         = k_fire0;
                if (BUTTONS >= 2) kbd[JOY_BTN0 + 1] = k_fire1;
                kbd[JOY_BTN0+BUTTONS] = k_start0;
            end
            if (p == 1) kbd[JOY_BTN0+BUTTONS] = k_start1;
        end

        assign raw        = io.joystick[16*p +: 16] | kbd;
        assign unused_raw = ^raw;

        // rot/cln are {U,D,L,R}, matching joystick bits [3:0]
        always_comb begin
            rot = raw[3:0];
            case (rotate_t'(io.rotate))
                ROT_CW90:  rot = {raw[JOY_L], raw[JOY_R], raw[JOY_D], raw[JOY_U]};
                ROT_180:   rot = {raw[JOY_D], raw[JOY_U], raw[JOY_R], raw[JOY_L]};
                ROT_CCW90: rot = {raw[JOY_R], raw[JOY_L], raw[JOY_U], raw[JOY_D]};
                default: ;
            endcase
        end

        assign cln[3:2] = (rot[3] && rot[2]) ? 2'b00 : rot[3:2];
        assign cln[1:0] = (rot[1] && rot[0]) ? 2'b00 : rot[1:0];

        always_comb begin
            fire = raw[JOY_BTN0 +: BUTTONS];
`ifdef INPUT_AUTOFIRE_EN
            if (io.autofire_en[p]) fire[0] = raw[JOY_BTN0] & af_phase;
`endif
        end

        assign dir_nx[4*p +: 4]             = cln;
        assign btn_nx[BUTTONS*p +: BUTTONS] = fire;

        coin_start_seq #(
            .COIN_TICKS(COIN_TICKS)
        ) u_seq (
            .clk_sys(clk_sys),
            .reset  (reset),
            .ce     (ce),
            .req    (raw[JOY_BTN0+BUTTONS]),
            .coin   (io.coin[p]),
            .start  (io.start[p])
        );
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            io.dir <= '0;
            io.btn <= '0;
        end else begin
            io.dir <= dir_nx;
            io.btn <= btn_nx;
        end
    end
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb/tb_arcade_input_ctrl.sv - directed stimulus with a reference model compared every cycle
module tb_arcade_input_ctrl;
    localparam int PLAYERS    = 2;
    localparam int BUTTONS    = 4;
    localparam int COIN_TICKS = 4;
    localparam int AF_TICKS   = 2;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic ce      = 1'b0;
    int   ce_div  = 0;
    int   checks  = 0;
    int   passed  = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if #(.PLAYERS(PLAYERS), .BUTTONS(BUTTONS)) io();

    arcade_input_ctrl #(
        .PLAYERS(PLAYERS), .BUTTONS(BUTTONS),
        .COIN_TICKS(COIN_TICKS), .AF_TICKS(AF_TICKS)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .ce     (ce),
        .io     (io)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    task automatic key(input logic [8:0] code, input bit pressed);
        io.ps2_key = {~io.ps2_key[10], pressed, code};
    endtask

    // ---------------- reference model ----------------
    bit   kst[8];            // U D L R fire0 fire1 start0 start1
    logic tog_m;
    int   t_m[PLAYERS];
    bit   act_m[PLAYERS];
    bit   reqp_m[PLAYERS];
    int   af_ticks_m;
    logic [4*PLAYERS-1:0]       exp_dir   = '0;
    logic [BUTTONS*PLAYERS-1:0] exp_btn   = '0;
    logic [PLAYERS-1:0]         exp_coin  = '0;
    logic [PLAYERS-1:0]         exp_start = '0;
    logic [15:0]                m_word;
    logic [BUTTONS-1:0]         m_fire;
    bit                         m_cw[4];
    bit                         m_o[4];
    bit                         m_req;
    int                         m_sh;

    function automatic int key_index(input logic [8:0] code);
        case (code)
            9'h175: return 0;
            9'h172: return 1;
            9'h16B: return 2;
            9'h174: return 3;
            9'h029, 9'h014: return 4;
            9'h011: return 5;
            9'h005: return 6;
            9'h006: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic logic [15:0] kbd_word(input int p);
        logic [15:0] w;
        w = '0;
        if (p == 0) begin
            w[3] = kst[0]; w[2] = kst[1]; w[1] = kst[2]; w[0] = kst[3];
            w[4] = kst[4]; w[5] = kst[5]; w[4+BUTTONS] = kst[6];
        end
        if (p == 1) w[4+BUTTONS] = kst[7];
        return w;
    endfunction

    always begin
        @(posedge clk_sys or posedge reset);
        if (reset) begin
            for (int i = 0; i < 8; i++) kst[i] = 1'b0;
            tog_m = 1'b0;
            af_ticks_m = 0;
            for (int p = 0; p < PLAYERS; p++) begin
                t_m[p] = 0; act_m[p] = 1'b0; reqp_m[p] = 1'b1;
            end
            exp_dir = '0; exp_btn = '0; exp_coin = '0; exp_start = '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                m_word = io.joystick[16*p +: 16] | kbd_word(p);
                // directions in clockwise order U,R,D,L; rotation is a cyclic shift
                m_cw[0] = m_word[3]; m_cw[1] = m_word[0]; m_cw[2] = m_word[2]; m_cw[3] = m_word[1];
                m_sh = (4 - int'(io.rotate)) % 4;
                for (int i = 0; i < 4; i++) m_o[i] = m_cw[(i + m_sh) % 4];
                if (m_o[0] && m_o[2]) begin m_o[0] = 1'b0; m_o[2] = 1'b0; end
                if (m_o[1] && m_o[3]) begin m_o[1] = 1'b0; m_o[3] = 1'b0; end
                exp_dir[4*p +: 4] = {m_o[0], m_o[2], m_o[3], m_o[1]};
                m_fire = m_word[4 +: BUTTONS];
`ifdef INPUT_AUTOFIRE_EN
                if (io.autofire_en[p]) m_fire[0] = m_fire[0] & (((af_ticks_m / AF_TICKS) % 2) == 1);
`endif
                exp_btn[BUTTONS*p +: BUTTONS] = m_fire;
                // coin/start as elapsed ce ticks since the trigger: coin [0,C), gap [C,2C), start >= 2C
                m_req = m_word[4+BUTTONS];
                if (!act_m[p]) begin
                    if (m_req && !reqp_m[p]) begin act_m[p] = 1'b1; t_m[p] = 0; end
                end else begin
                    if (ce && t_m[p] < 3*COIN_TICKS) t_m[p]++;
                    if (t_m[p] >= 3*COIN_TICKS && !m_req) act_m[p] = 1'b0;
                end
                reqp_m[p] = m_req;
                exp_coin[p]  = act_m[p] && (t_m[p] < COIN_TICKS);
                exp_start[p] = act_m[p] && (t_m[p] >= 2*COIN_TICKS);
            end
            if (ce) af_ticks_m++;
            if (io.ps2_key[10] != tog_m) begin
                if (key_index(io.ps2_key[8:0]) >= 0) kst[key_index(io.ps2_key[8:0])] = io.ps2_key[9];
            end
            tog_m = io.ps2_key[10];
        end
    end

    always begin
        @(negedge clk_sys);
        if (!reset) begin
            check("model_dir",   32'(io.dir),   32'(exp_dir));
            check("model_btn",   32'(io.btn),   32'(exp_btn));
            check("model_coin",  32'(io.coin),  32'(exp_coin));
            check("model_start", 32'(io.start), 32'(exp_start));
        end
    end

    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            ce = (ce_div == 3);
            ce_div = (ce_div + 1) % 4;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int  cc, gc, sc, toggles;
    bit  done, seen_start, steady;
    logic prev_b0;

    initial begin
        io.ps2_key = '0; io.joystick = '0; io.rotate = 2'd0; io.autofire_en = '0;
        tick(2);
        check("reset_dir",   32'(io.dir),   32'h0);
        check("reset_btn",   32'(io.btn),   32'h0);
        check("reset_coin",  32'(io.coin),  32'h0);
        check("reset_start", 32'(io.start), 32'h0);
        reset = 1'b0;

        io.joystick[15:0] = 16'h0008; tick(1);
        check("joy_up", 32'(io.dir[3:0]), 32'h8);
        io.rotate = 2'd1; io.joystick[15:0] = 16'h0002; tick(1);
        check("rot_cw90_left", 32'(io.dir[3:0]), 32'h8);
        io.rotate = 2'd2; tick(1);
        check("rot_180_left", 32'(io.dir[3:0]), 32'h1);
        io.rotate = 2'd3; tick(1);
        check("rot_ccw90_left", 32'(io.dir[3:0]), 32'h4);
        io.rotate = 2'd0; io.joystick = '0; tick(1);

        key(9'h175, 1'b1); tick(1);
        check("key_up_lat1", 32'(io.dir[3]), 32'h0);
        tick(1);
        check("key_up_lat2", 32'(io.dir[3]), 32'h1);
        key(9'h175, 1'b0); tick(2);
        check("key_up_release", 32'(io.dir[3]), 32'h0);
        key(9'h01C, 1'b1); tick(2);
        check("key_unlisted", 32'({io.dir, io.btn}), 32'h0);
        key(9'h029, 1'b1); tick(2);
        check("key_fire0_a", 32'(io.btn[0]), 32'h1);
        key(9'h014, 1'b0); tick(2);
        check("key_fire0_b_release", 32'(io.btn[0]), 32'h0);

        io.joystick[15:0] = 16'h000C; tick(1);
        check("cancel_ud", 32'(io.dir[3:0]), 32'h0);
        io.joystick[15:0] = 16'h000D; tick(1);
        check("cancel_ud_plus_r", 32'(io.dir[3:0]), 32'h1);
        io.joystick = '0; tick(1);

        io.joystick[16+4+BUTTONS] = 1'b1; tick(1);
        check("coin1_rise", 32'(io.coin[1]), 32'h1);
        io.joystick[16+4+BUTTONS] = 1'b0;
        cc = 0; gc = 0; sc = 0; done = 1'b0; seen_start = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (io.coin[1]) begin
                if (ce) cc++;
            end else if (io.start[1]) begin
                seen_start = 1'b1;
                if (ce) sc++;
            end else if (seen_start) begin
                done = 1'b1;
            end else if (ce) begin
                gc++;
            end
            if (!done) tick(1);
        end
        check("seq_completes", 32'(done), 32'h1);
        check("coin_ticks",  32'(cc), 32'(COIN_TICKS));
        check("gap_ticks",   32'(gc), 32'(COIN_TICKS));
        check("start_ticks", 32'(sc), 32'(COIN_TICKS));

        io.joystick[4+BUTTONS] = 1'b1; tick(1);
        check("coin0_rise", 32'(io.coin[0]), 32'h1);
        tick(2);
        reset = 1'b1; #1;
        check("reset_async_coin", 32'(io.coin[0]), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("no_retrigger_held", 32'(io.coin[0]), 32'h0);
        io.joystick[4+BUTTONS] = 1'b0; tick(1);
        io.joystick[4+BUTTONS] = 1'b1; tick(1);
        check("retrigger_edge", 32'(io.coin[0]), 32'h1);
        io.joystick[4+BUTTONS] = 1'b0;
        tick(60);
        check("seq_idle", 32'({io.coin, io.start}), 32'h0);

        io.autofire_en = 2'b01; io.joystick[4] = 1'b1; tick(1);
        toggles = 0; steady = 1'b1; prev_b0 = io.btn[0];
        for (int i = 0; i < 48; i++) begin
            tick(1);
            if (io.btn[0] !== prev_b0) toggles++;
            if (io.btn[0] !== 1'b1) steady = 1'b0;
            prev_b0 = io.btn[0];
        end
`ifdef INPUT_AUTOFIRE_EN
        check("af_toggles", 32'(toggles >= 5), 32'h1);
`else
        check("af_disabled_steady", 32'(steady), 32'h1);
`endif
        io.joystick = '0; io.autofire_en = '0;
        tick(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/arcade_input_ctrl.md
# arcade_input_ctrl

Parametrised player-input front end for arcade cores. It merges PS/2 keyboard events and per-player MiSTer joysticks, and applies screen-rotation remapping and opposite-direction cancelling. It also generates a timed coin-then-start sequence per player and optional autofire. It sits between `hps_io` and the game core, replacing ad-hoc key/joystick glue in the `emu` top level.

## Interface
Parameters:
- `PLAYERS`, 2, number of player channels (1..4).
- `BUTTONS`, 4, fire buttons per player (1..8); taken from joystick bits [4+BUTTONS-1:4].
- `COIN_TICKS`, 16, length of each coin / gap / minimum-start phase, in `ce` ticks (≥1).
- `AF_TICKS`, 8, autofire half-period, in `ce` ticks (≥1).

Ports:
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  timing-tick enable (6 MHz in existing cores).
- `ps2_key`  in  11  [10] toggles on each event, [9] pressed, [8:0] scan code (bit 8 = E0 extended).
- `joystick`  in  16*PLAYERS  per-player MiSTer word: bit 0 R, 1 L, 2 D, 3 U, 4.. buttons, then 4+BUTTONS start.
- `rotate`  in  2  0 none, 1 CW90, 2 180, 3 CCW90.
- `autofire_en`  in  PLAYERS  per-player autofire enable on button 0.
- `dir`  out  4*PLAYERS  per player {up,down,left,right}, active-high.
- `btn`  out  BUTTONS*PLAYERS  active-high.
- `coin`  out  PLAYERS  coin pulse.
- `start`  out  PLAYERS  start level.

## Operation
- Keyboard drives player 0 only. Keys: 0x175 U, 0x172 D, 0x16B L, 0x174 R, 0x029/0x014 btn0, 0x011 btn1, 0x005 start P0, 0x006 start P1 (when PLAYERS≥2). Unlisted codes are ignored.
- Key event: when `ps2_key[10]` differs from its registered copy, the matching key-state bit is set to `ps2_key[9]`.
- Merge: raw = key state OR joystick, per bit.
- Rotation of {U,D,L,R}:
  - CW90: U←L, D←R, L←D, R←U.
  - 180: U←D, D←U, L←R, R←L.
  - CCW90: U←R, D←L, L←U, R←D.
- Opposite cancel runs after rotation: U&D both set → both 0; L&R both set → both 0.
- Autofire: one shared counter on `ce` toggles `af_phase` every AF_TICKS. When `autofire_en[p]` is set, btn0 = held & `af_phase`.
- Coin/start FSM, one per player, counting on `ce`:
  - IDLE: on the rising edge of the start request, go to COIN.
  - COIN: `coin`=1 for COIN_TICKS, then GAP.
  - GAP: all outputs 0 for COIN_TICKS, then START.
  - START: `start`=1; return to IDLE once at least COIN_TICKS have elapsed and the request is low.
  - A request that stays held does not retrigger; a new rising edge is needed.

## Timing
- Every output is registered. Reset values: `dir`, `btn`, `coin`, `start` = 0; key states 0; all FSMs IDLE; counters 0; `af_phase` 0.
- Latency, joystick → `dir`/`btn`: 1 clk_sys.
- Latency, `ps2_key` event → `dir`/`btn`: 2 clk_sys.
- `rotate` change takes effect on the next edge; no glitch filtering.
- COIN asserts on the first edge after the request rising edge is sampled, regardless of `ce`. Phase counters advance only when `ce`=1.
- A start request that rises during COIN or GAP is ignored. A request that falls early does not shorten COIN, GAP or the minimum START time.
- Reset mid-sequence: `coin`/`start` drop immediately (asynchronously) and the FSM goes to IDLE. A request still held after reset release needs a fresh rising edge.
- Counters are $clog2(COIN_TICKS+1) and $clog2(AF_TICKS+1) bits wide and never wrap.

## Configuration
- `INPUT_AUTOFIRE_EN`: when defined, the autofire counter is built and `autofire_en` is honoured.
- When undefined, no counter is built, `autofire_en` is ignored, and btn0 passes straight through.

## Structure
- Package `arcade_input_pkg`:
  - joystick bit indices;
  - `rotate_t` enum;
  - scan-code localparams;
  - `coin_state_t` enum {IDLE, COIN, GAP, START}.
- Sub-module `coin_start_seq` (one per player, instantiated with generate): inputs `clk_sys`, `reset`, `ce`, `req`; outputs `coin`, `start`.
- Top level contains the key decode, merge, rotation, cancel, autofire and output registers.

## Test plan
- Reset, then joystick P0 = 0x0008, rotate=0 → `dir[3:0]`=4'b1000 one clk later; with rotate=1, input L (0x0002) → `dir[3:0]`=4'b1000.
- ps2_key event 0x175 pressed (toggle flip) → P0 up=1 after 2 clks; release event → up=0 after 2 clks.
- Joystick U|D (0x000C) → `dir` up=down=0; adding R → only right=1.
- COIN_TICKS=4, `ce` every 4th clk, start P1 pulse of 1 clk → `coin[1]` high 4 ticks, low 4 ticks, `start[1]` high 4 ticks, then low.
- Reset asserted during COIN with the request still held → `coin` 0 immediately; after release, no coin until the request toggles low then high.
- With `INPUT_AUTOFIRE_EN`, AF_TICKS=2, btn0 held, `autofire_en`=1 → btn0 toggles every 2 `ce` ticks; without the macro → btn0 steady 1.
